fmmu_read_engine: RTL and testbench

FMMU_READ_ENGINE -- requirements
Module: fmmu_read_engine

---
 rtl/fmmu_read_engine.sv | 242 ++++++++++++++++++++++++
 tb/tb_fmmu_read_engine.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmmu_read_engine.sv
// FMMU read engine: walks a datagram byte by byte, fetching bytes that fall inside the
// FMMU logical window from physical memory and emitting zeros for the rest.
module fmmu_read_engine #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [31:0] sub_address,
  input  logic [7:0]  sub_len,
  input  logic        subdv,
  input  logic [31:0] fmmu_logic_address_start,
  input  logic [7:0]  fmmu_logic_length,
  input  logic [15:0] fmmu_physical_address_start,
  input  logic        fmmu_enable,
  output logic        mem_rd_req,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rd_data,
  input  logic        mem_rd_ack,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_mapped,
  output logic        tx_last,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic [7:0]  map_count
);

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 8;
  localparam int unsigned PW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_RD_REQ, S_RD_WAIT, S_EMIT, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]   acc_q, acc_d;
  logic [AW-1:0]   sub_addr_q, sub_addr_d;
  logic [LW-1:0]   len_q, len_d;
  logic [AW-1:0]   win_start_q, win_start_d;
  logic [LW-1:0]   win_len_q, win_len_d;
  logic [PW-1:0]   win_phys_q, win_phys_d;
  logic            win_en_q, win_en_d;
  logic            req_q, req_d;
  logic [PW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   txd_q, txd_d;
  logic            txv_q, txv_d;
  logic            txm_q, txm_d;
  logic            txl_q, txl_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [LW-1:0]   mapcnt_q, mapcnt_d;

  // Mapping of the byte about to be started (index 0 from CHECK, idx+1 from EMIT)
  logic [LW-1:0]   nidx;
  logic [AW:0]     lin, win_lo, win_hi;
  logic            nmapped, nlast;
  logic [PW-1:0]   naddr;
  logic            load_byte;

  always_comb begin
    nidx    = (state_q == S_EMIT) ? idx_q + LW'(1) : '0;
    lin     = {1'b0, sub_addr_q} + (AW+1)'(nidx);
    win_lo  = {1'b0, win_start_q};
    win_hi  = win_lo + (AW+1)'(win_len_q);
    nmapped = win_en_q && (lin >= win_lo) && (lin < win_hi);
    naddr   = win_phys_q + PW'(lin - win_lo);
    nlast   = (nidx == len_q - LW'(1));
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sub_addr_d  = sub_addr_q;
    len_d       = len_q;
    win_start_d = win_start_q;
    win_len_d   = win_len_q;
    win_phys_d  = win_phys_q;
    win_en_d    = win_en_q;
    req_d       = req_q;
    addr_d      = addr_q;
    txd_d       = txd_q;
    txv_d       = txv_q;
    txm_d       = txm_q;
    txl_d       = txl_q;
    busy_d      = busy_q;
    mapcnt_d    = mapcnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    load_byte   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (subdv) begin
          sub_addr_d  = sub_address;
          len_d       = sub_len;
          win_start_d = fmmu_logic_address_start;
          win_len_d   = fmmu_logic_length;
          win_phys_d  = fmmu_physical_address_start;
          win_en_d    = fmmu_enable;
          idx_d       = '0;
          acc_d       = '0;
          busy_d      = 1'b1;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (len_q == '0) begin
          done_d   = 1'b1;
          mapcnt_d = acc_q;
          state_d  = S_DONE;
        end else begin
          load_byte = 1'b1;
        end
      end
      S_RD_REQ: begin
        cnt_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem_rd_ack) begin
          req_d   = 1'b0;
          txd_d   = mem_rd_data;
          txm_d   = 1'b1;
          txl_d   = (idx_q == len_q - LW'(1));
          txv_d   = 1'b1;
          acc_d   = acc_q + LW'(1);
          state_d = S_EMIT;
        end else if (cnt_q == TO_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_EMIT: begin
        if (tx_ready) begin
          txv_d = 1'b0;
          if (txl_q) begin
            txl_d    = 1'b0;
            done_d   = 1'b1;
            mapcnt_d = acc_q;
            state_d  = S_DONE;
          end else begin
            idx_d     = nidx;
            load_byte = 1'b1;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Start the next byte: memory fetch when mapped, immediate zero byte otherwise
    if (load_byte) begin
      if (nmapped) begin
        req_d   = 1'b1;
        addr_d  = naddr;
        state_d = S_RD_REQ;
      end else begin
        txv_d   = 1'b1;
        txd_d   = '0;
        txm_d   = 1'b0;
        txl_d   = nlast;
        state_d = S_EMIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      sub_addr_q  <= '0;
      len_q       <= '0;
      win_start_q <= '0;
      win_len_q   <= '0;
      win_phys_q  <= '0;
      win_en_q    <= 1'b0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      txd_q       <= '0;
      txv_q       <= 1'b0;
      txm_q       <= 1'b0;
      txl_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mapcnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sub_addr_q  <= sub_addr_d;
      len_q       <= len_d;
      win_start_q <= win_start_d;
      win_len_q   <= win_len_d;
      win_phys_q  <= win_phys_d;
      win_en_q    <= win_en_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      txd_q       <= txd_d;
      txv_q       <= txv_d;
      txm_q       <= txm_d;
      txl_q       <= txl_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mapcnt_q    <= mapcnt_d;
    end
  end

  assign mem_rd_req  = req_q;
  assign mem_addr    = addr_q;
  assign tx_data     = txd_q;
  assign tx_valid    = txv_q;
  assign tx_mapped   = txm_q;
  assign tx_last     = txl_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_timeout = err_q;
  assign map_count   = mapcnt_q;

endmodule

// File: tb/tb_fmmu_read_engine.sv
// Scoreboard bench for fmmu_read_engine: a window-arithmetic reference model queues the
// expected reads, bytes and completions; independent monitors pop and compare them.
module tb_fmmu_read_engine;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        RST;
  logic [31:0] sub_address;
  logic [7:0]  sub_len;
  logic        subdv;
  logic [31:0] fmmu_logic_address_start;
  logic [7:0]  fmmu_logic_length;
  logic [15:0] fmmu_physical_address_start;
  logic        fmmu_enable;
  logic        mem_rd_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rd_data;
  logic        mem_rd_ack;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_mapped;
  logic        tx_last;
  logic        busy;
  logic        done;
  logic        err_timeout;
  logic [7:0]  map_count;

  fmmu_read_engine #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .RST(RST),
    .sub_address(sub_address), .sub_len(sub_len), .subdv(subdv),
    .fmmu_logic_address_start(fmmu_logic_address_start),
    .fmmu_logic_length(fmmu_logic_length),
    .fmmu_physical_address_start(fmmu_physical_address_start),
    .fmmu_enable(fmmu_enable),
    .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .mem_rd_ack(mem_rd_ack),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_mapped(tx_mapped), .tx_last(tx_last),
    .busy(busy), .done(done), .err_timeout(err_timeout), .map_count(map_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       mapped;
    logic       last;
  } txb_t;

  txb_t        exp_tx[$];
  logic [15:0] exp_addr[$];
  logic [7:0]  exp_done[$];
  int          err_pending = 0;
  int          ack_mode = 0;
  int          stall_cnt = 0;
  bit          rdy_rand = 1'b0;
  logic [7:0]  mem [65536];
  logic [7:0]  last_map = 8'h00;
  int          total = 0;
  int          passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  task automatic fail(input string name);
    total++;
    $display("FAIL %s: actual=event required=none", name);
  endtask

  // Reference model: byte i maps when start <= sa+i < start+len in wide arithmetic.
  // mode 1 stops at the first mapped byte, which is expected to time out.
  task automatic model_req(input logic [31:0] sa, input logic [7:0] sl,
                           input logic [31:0] ws, input logic [7:0] wl,
                           input logic [15:0] wp, input logic we, input int mode);
    int          nmap;
    logic [63:0] lin;
    logic [15:0] a;
    bit          m;
    bit          lst;
    nmap = 0;
    for (int i = 0; i < int'(sl); i++) begin
      lin = 64'(sa) + 64'(i);
      m   = we && (lin >= 64'(ws)) && (lin < 64'(ws) + 64'(wl));
      lst = (i == int'(sl) - 1);
      if (m) begin
        a = wp + 16'(lin - 64'(ws));
        exp_addr.push_back(a);
        if (mode == 1) begin
          err_pending++;
          return;
        end
        nmap++;
        exp_tx.push_back({mem[a], 1'b1, lst});
      end else begin
        exp_tx.push_back({8'h00, 1'b0, lst});
      end
    end
    exp_done.push_back(8'(nmap));
    last_map = 8'(nmap);
  endtask

  task automatic check_reset_vals();
    chk("rst_mem_rd_req", 64'(mem_rd_req), 64'(0));
    chk("rst_tx_valid", 64'(tx_valid), 64'(0));
    chk("rst_tx_last", 64'(tx_last), 64'(0));
    chk("rst_tx_mapped", 64'(tx_mapped), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err_timeout), 64'(0));
    chk("rst_tx_data", 64'(tx_data), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_map_count", 64'(map_count), 64'(0));
  endtask

  task automatic scramble();
    sub_address                 = $urandom;
    sub_len                     = 8'($urandom);
    fmmu_logic_address_start    = $urandom;
    fmmu_logic_length           = 8'($urandom);
    fmmu_physical_address_start = 16'($urandom);
    fmmu_enable                 = 1'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((busy || exp_tx.size() != 0 || exp_done.size() != 0 || err_pending != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) fail("completion_timeout");
  endtask

  // Issue one request, check latency, then pulse a strobe while busy that must be ignored
  task automatic run_req(input logic [31:0] sa, input logic [7:0] sl, input logic [31:0] ws,
                         input logic [7:0] wl, input logic [15:0] wp, input logic we,
                         input int mode, input bit wait_end);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) fail("idle_wait");
    ack_mode = mode;
    if (mode != 2) model_req(sa, sl, ws, wl, wp, we, mode);
    sub_address = sa; sub_len = sl;
    fmmu_logic_address_start = ws; fmmu_logic_length = wl;
    fmmu_physical_address_start = wp; fmmu_enable = we;
    subdv = 1'b1;
    @(posedge clk); #1;
    subdv = 1'b0;
    scramble();
    chk("busy_after_accept", 64'(busy), 64'(1));
    @(posedge clk); #1;
    if (sl == 8'd0) begin
      chk("len0_done_latency", 64'(done), 64'(1));
      chk("len0_no_req", 64'(mem_rd_req), 64'(0));
      chk("len0_no_valid", 64'(tx_valid), 64'(0));
    end else begin
      chk("first_latency", 64'(mem_rd_req | tx_valid), 64'(1));
    end
    subdv = 1'b1;
    @(posedge clk); #1;
    subdv = 1'b0;
    if (wait_end) wait_done();
  endtask

  // Memory responder: checks each read address, acks after 1..4 cycles or withholds the ack
  initial begin
    mem_rd_ack  = 1'b0;
    mem_rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_rd_req) begin
        int          d;
        int          n;
        logic [15:0] a;
        a = mem_addr;
        if (ack_mode != 2) begin
          if (exp_addr.size() == 0) fail("rd_unexpected");
          else chk("mem_addr", 64'(a), 64'(exp_addr.pop_front()));
        end
        if (ack_mode == 0) begin
          d = int'($urandom_range(1, 4));
          repeat (d) @(posedge clk);
          #1;
          mem_rd_ack  = 1'b1;
          mem_rd_data = mem[a];
          @(posedge clk); #1;
          mem_rd_ack  = 1'b0;
          mem_rd_data = 8'($urandom);
        end else begin
          n = 1;
          while (mem_rd_req && n < int'(TO) + 10) begin
            @(negedge clk);
            if (mem_rd_req) n++;
          end
          if (ack_mode == 1) chk("timeout_req_cycles", 64'(n), 64'(TO + 1));
          if (mem_rd_req) fail("req_stuck");
        end
      end
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_cnt > 0) begin
        tx_ready = 1'b0;
        stall_cnt--;
      end else begin
        tx_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Byte monitor: compares each handshaken byte and checks hold stability while stalled
  initial begin
    bit         have_held;
    logic [9:0] held;
    have_held = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (tx_valid) begin
        if (have_held) chk("tx_hold", 64'({tx_data, tx_mapped, tx_last}), 64'(held));
        if (tx_ready) begin
          have_held = 1'b0;
          if (exp_tx.size() == 0) fail("tx_unexpected");
          else chk("tx_byte", 64'({tx_data, tx_mapped, tx_last}), 64'(exp_tx.pop_front()));
        end else begin
          held = {tx_data, tx_mapped, tx_last};
          have_held = 1'b1;
        end
      end else begin
        have_held = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_done.size() == 0) fail("done_unexpected");
        else chk("map_count", 64'(map_count), 64'(exp_done.pop_front()));
      end
      if (err_timeout) begin
        if (err_pending == 0) fail("err_unexpected");
        else begin
          err_pending--;
          chk("err_busy_low", 64'(busy), 64'(0));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] ws, sa;
    RST = 1'b1;
    subdv = 1'b0;
    scramble();
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h1003] = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    RST = 1'b0;
    @(posedge clk); #1;

    run_req(32'h14141412, 8'd8, 32'h14141414, 8'd3, 16'h1001, 1'b1, 0, 1'b1);
    run_req(32'h10000000, 8'd1, 32'h14141414, 8'd3, 16'h1001, 1'b1, 0, 1'b1);
    run_req(32'h14141416, 8'd1, 32'h14141414, 8'd3, 16'h1001, 1'b1, 0, 1'b1);
    run_req(32'h14141414, 8'd0, 32'h14141414, 8'd3, 16'h1001, 1'b1, 0, 1'b1);
    run_req(32'h14141414, 8'd4, 32'h14141414, 8'd0, 16'h1001, 1'b1, 0, 1'b1);
    run_req(32'h14141414, 8'd4, 32'h14141414, 8'd3, 16'h1001, 1'b0, 0, 1'b1);
    run_req(32'hFFFFFFFE, 8'd4, 32'hFFFFFFFC, 8'd10, 16'hFFFE, 1'b1, 0, 1'b1);

    // Ack withheld: abort with err_timeout, map_count untouched
    run_req(32'h14141413, 8'd3, 32'h14141414, 8'd3, 16'h2000, 1'b1, 1, 1'b1);
    chk("timeout_busy", 64'(busy), 64'(0));
    chk("timeout_map_hold", 64'(map_count), 64'(last_map));
    ack_mode = 0;

    // Five-cycle downstream stall in the middle of an unmapped stream
    run_req(32'h30000000, 8'd6, 32'h14141414, 8'd3, 16'h1001, 1'b1, 0, 1'b0);
    n = 0;
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!tx_valid) fail("stall_no_valid");
    stall_cnt = 5;
    wait_done();

    // Reset while waiting for a read ack
    run_req(32'h14141414, 8'd2, 32'h14141414, 8'd3, 16'h1001, 1'b1, 2, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_req", 64'(mem_rd_req), 64'(1));
    RST = 1'b1;
    @(posedge clk); #1;
    check_reset_vals();
    RST = 1'b0;
    exp_tx.delete();
    exp_addr.delete();
    exp_done.delete();
    last_map = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    ack_mode = 0;

    rdy_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      ws = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15)) : $urandom;
      sa = ws + 32'($urandom_range(0, 30)) - 32'd10;
      run_req(sa, 8'($urandom_range(0, 12)), ws, 8'($urandom_range(0, 20)),
              16'($urandom), 1'($urandom_range(0, 4) != 0), 0, 1'b1);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("end_tx_queue", 64'(exp_tx.size()), 64'(0));
    chk("end_addr_queue", 64'(exp_addr.size()), 64'(0));
    chk("end_done_queue", 64'(exp_done.size()), 64'(0));
    chk("end_idle", 64'(busy), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
